// File: rtl/instr_fetch_ctrl_if.sv
// Bus between the fetch controller and its environment: instruction
// memory port, branch redirect, and the valid/ready stream to decode.
interface instr_fetch_ctrl_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic               start;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               halted;

  // Fetch controller side
  modport master (
    input  start, imem_data, redirect_valid, redirect_pc, instr_ready,
    output imem_addr, instr_valid, instr, instr_pc, halted
  );

  // Environment side (memory, branch unit, decode)
  modport slave (
    output start, imem_data, redirect_valid, redirect_pc, instr_ready,
    input  imem_addr, instr_valid, instr, instr_pc, halted
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues reads to a 1-cycle
// registered instruction memory, buffers returned words in a 2-entry FIFO
// towards decode, and handles branch redirects and the HALT word.
module instr_fetch_ctrl #(
  parameter int                  ADDR_W    = 8,
  parameter int                  INSTR_W   = 16,
  parameter logic [ADDR_W-1:0]   RESET_PC  = {ADDR_W{1'b0}},
  parameter logic [INSTR_W-1:0]  HALT_WORD = {INSTR_W{1'b0}}
) (
  input  logic                 clk,
  input  logic                 reset_n,
  instr_fetch_ctrl_if.master   bus
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_W / 8);
  localparam logic [ADDR_W-1:0] PC_ALIGN_MASK = {{(ADDR_W-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t             state_r;
  logic [ADDR_W-1:0]  fetch_pc_r;
  logic [ADDR_W-1:0]  tag_pc_r;
  logic               inflight_r;
  logic               halted_r;
  logic [1:0]         count_r;
  logic [INSTR_W-1:0] data0_r;
  logic [INSTR_W-1:0] data1_r;
  logic [ADDR_W-1:0]  pc0_r;
  logic [ADDR_W-1:0]  pc1_r;

  logic               valid_s;
  logic               pop_s;
  logic               halt_pop_s;
  logic               issue_s;
  logic [2:0]         occupancy_s;
  logic [1:0]         wr_slot_s;
  logic [1:0]         count_nxt_s;
  logic [INSTR_W-1:0] data0_nxt_s;
  logic [INSTR_W-1:0] data1_nxt_s;
  logic [ADDR_W-1:0]  pc0_nxt_s;
  logic [ADDR_W-1:0]  pc1_nxt_s;

  // Handshake decode: a redirect hides the head and blocks both pop and issue.
  always_comb begin
    valid_s     = (count_r != 2'd0) && !bus.redirect_valid;
    pop_s       = valid_s && bus.instr_ready;
    halt_pop_s  = pop_s && (data0_r == HALT_WORD);
    occupancy_s = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    issue_s     = (state_r == ST_RUN) && !bus.redirect_valid && (occupancy_s < 3'd2);
  end

  // Shift-style FIFO next state: pop moves slot1 to slot0, push lands behind the survivors.
  always_comb begin
    data0_nxt_s = data0_r;
    data1_nxt_s = data1_r;
    pc0_nxt_s   = pc0_r;
    pc1_nxt_s   = pc1_r;
    wr_slot_s   = count_r - {1'b0, pop_s};
    count_nxt_s = count_r - {1'b0, pop_s} + {1'b0, inflight_r};
    if (pop_s) begin
      data0_nxt_s = data1_r;
      pc0_nxt_s   = pc1_r;
    end else begin
      data0_nxt_s = data0_r;
      pc0_nxt_s   = pc0_r;
    end
    if (inflight_r) begin
      if (wr_slot_s == 2'd0) begin
        data0_nxt_s = bus.imem_data;
        pc0_nxt_s   = tag_pc_r;
      end else begin
        data1_nxt_s = bus.imem_data;
        pc1_nxt_s   = tag_pc_r;
      end
    end else begin
      count_nxt_s = count_r - {1'b0, pop_s};
    end
  end

  // Fetch FSM, PC, in-flight tracking and FIFO storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      fetch_pc_r <= RESET_PC;
      tag_pc_r   <= {ADDR_W{1'b0}};
      inflight_r <= 1'b0;
      halted_r   <= 1'b0;
      count_r    <= 2'd0;
      data0_r    <= {INSTR_W{1'b0}};
      data1_r    <= {INSTR_W{1'b0}};
      pc0_r      <= {ADDR_W{1'b0}};
      pc1_r      <= {ADDR_W{1'b0}};
    end else if (bus.redirect_valid) begin
      // Flush: buffered words and the returning read are dropped.
      state_r    <= ST_RUN;
      fetch_pc_r <= bus.redirect_pc & PC_ALIGN_MASK;
      inflight_r <= 1'b0;
      halted_r   <= 1'b0;
      count_r    <= 2'd0;
    end else if (halt_pop_s) begin
      // HALT word delivered; everything behind it is discarded.
      state_r    <= ST_HALTED;
      inflight_r <= 1'b0;
      halted_r   <= 1'b1;
      count_r    <= 2'd0;
      if (issue_s) begin
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end else begin
        fetch_pc_r <= fetch_pc_r;
      end
    end else begin
      case (state_r)
        ST_IDLE:   state_r <= bus.start ? ST_RUN : ST_IDLE;
        ST_RUN:    state_r <= ST_RUN;
        ST_HALTED: state_r <= ST_HALTED;
        default:   state_r <= ST_IDLE;
      endcase
      count_r <= count_nxt_s;
      data0_r <= data0_nxt_s;
      data1_r <= data1_nxt_s;
      pc0_r   <= pc0_nxt_s;
      pc1_r   <= pc1_nxt_s;
      if (issue_s) begin
        inflight_r <= 1'b1;
        tag_pc_r   <= fetch_pc_r;
        fetch_pc_r <= fetch_pc_r + PC_STEP;
      end else begin
        inflight_r <= 1'b0;
      end
    end
  end

  assign bus.imem_addr   = fetch_pc_r;
  assign bus.instr_valid = valid_s;
  assign bus.instr       = data0_r;
  assign bus.instr_pc    = pc0_r;
  assign bus.halted      = halted_r;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus a
// randomized run, compared against a queue-based reference model.
module tb_instr_fetch_ctrl;

  logic clk = 1'b0;
  logic reset_n;

  instr_fetch_ctrl_if bus ();

  instr_fetch_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: 128 words, registered read every edge.
  logic [15:0] mem [0:127];
  always @(posedge clk) bus.imem_data <= mem[bus.imem_addr[7:1]];

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] ins;
  } ent_t;

  // Reference model state
  ent_t       q[$];
  ent_t       log_q[$];
  int         m_state;   // 0 idle, 1 running, 2 halted
  bit         m_pend;
  logic [7:0] m_pend_pc;
  logic [7:0] m_pc;
  bit         m_halted;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_state  = 0;
    m_pend   = 1'b0;
    m_pc     = 8'h00;
    m_halted = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model.
  task automatic cycle(input bit s, input bit rd, input bit r, input logic [7:0] rpc);
    bit   exp_valid;
    bit   pop;
    bit   issue;
    bit   hpop;
    int   occ;
    ent_t e;
    @(negedge clk);
    bus.start          = s;
    bus.instr_ready    = rd;
    bus.redirect_valid = r;
    bus.redirect_pc    = rpc;
    #1;
    exp_valid = (q.size() != 0) && !r;
    check_eq("instr_valid", {31'd0, bus.instr_valid}, {31'd0, exp_valid});
    if (exp_valid) begin
      check_eq("instr", {16'd0, bus.instr}, {16'd0, q[0].ins});
      check_eq("instr_pc", {24'd0, bus.instr_pc}, {24'd0, q[0].pc});
    end
    check_eq("halted", {31'd0, bus.halted}, {31'd0, m_halted});
    check_eq("imem_addr", {24'd0, bus.imem_addr}, {24'd0, m_pc});
    pop = exp_valid && rd;
    if (pop) log_q.push_back(q[0]);
    if (r) begin
      q.delete();
      m_pend   = 1'b0;
      m_pc     = rpc & 8'hFE;
      m_halted = 1'b0;
      m_state  = 1;
    end else begin
      occ   = q.size() + int'(m_pend) - int'(pop);
      issue = (m_state == 1) && (occ < 2);
      hpop  = pop && (q[0].ins == 16'h0000);
      if (pop) void'(q.pop_front());
      if (m_pend) begin
        e.pc  = m_pend_pc;
        e.ins = mem[m_pend_pc[7:1]];
        q.push_back(e);
      end
      m_pend = 1'b0;
      if (hpop) begin
        q.delete();
        m_halted = 1'b1;
        m_state  = 2;
      end else if (issue) begin
        m_pend    = 1'b1;
        m_pend_pc = m_pc;
      end
      if (issue) m_pc = m_pc + 8'd2;
      if (m_state == 0 && s) m_state = 1;
    end
  endtask

  // Asynchronous reset pulse away from the clock edge, checked immediately.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
    check_eq("rst_halted", {31'd0, bus.halted}, 32'd0);
    check_eq("rst_instr", {16'd0, bus.instr}, 32'd0);
    check_eq("rst_instr_pc", {24'd0, bus.instr_pc}, 32'd0);
    check_eq("rst_imem_addr", {24'd0, bus.imem_addr}, 32'd0);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int ok;
    reset_n            = 1'b0;
    bus.start          = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 8'h00;
    for (int i = 0; i < 128; i++) mem[i] = 16'(($urandom % 16'hFFFF) + 1);
    mem[8'h00] = 16'h21FE;
    mem[8'h01] = 16'h22FB;
    mem[8'h02] = 16'h5823;
    mem[8'h11] = 16'h0467;
    mem[8'h1E] = 16'hD1FC;
    mem[8'h1F] = 16'h0000;
    mem[8'h7F] = 16'hA5A5;
    model_clear();
    do_reset();

    // 1: start with ready=1, first word after the third edge, back-to-back
    log_q.delete();
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("t1_latency_early", log_q.size(), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("t1_latency_first", log_q.size(), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("t1_count", log_q.size(), 32'd3);
    check_eq("t1_pc0", {24'd0, log_q[0].pc}, 32'h00);
    check_eq("t1_ins0", {16'd0, log_q[0].ins}, 32'h21FE);
    check_eq("t1_pc1", {24'd0, log_q[1].pc}, 32'h02);
    check_eq("t1_ins1", {16'd0, log_q[1].ins}, 32'h22FB);
    check_eq("t1_pc2", {24'd0, log_q[2].pc}, 32'h04);
    check_eq("t1_ins2", {16'd0, log_q[2].ins}, 32'h5823);

    // 2: backpressure for 5 cycles, then contiguous PCs
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    ok = 1;
    for (int i = 0; i + 1 < log_q.size(); i++)
      if (log_q[i+1].pc != log_q[i].pc + 8'd2) ok = 0;
    check_eq("t2_contiguous", ok, 32'd1);
    check_eq("t2_count", log_q.size(), 32'd9);

    // 3: redirect to 22 while FIFO is loaded
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b0, 1'b1, 8'h22);
    log_q.delete();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("t3_pc", {24'd0, log_q[0].pc}, 32'h22);
    check_eq("t3_ins", {16'd0, log_q[0].ins}, 32'h0467);

    // 4: redirect to 3C, HALT at 3E
    cycle(1'b0, 1'b1, 1'b1, 8'h3C);
    log_q.delete();
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("t4_count", log_q.size(), 32'd2);
    check_eq("t4_pc0", {24'd0, log_q[0].pc}, 32'h3C);
    check_eq("t4_ins0", {16'd0, log_q[0].ins}, 32'hD1FC);
    check_eq("t4_pc1", {24'd0, log_q[1].pc}, 32'h3E);
    check_eq("t4_ins1", {16'd0, log_q[1].ins}, 32'h0000);
    check_eq("t4_halted", {31'd0, bus.halted}, 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    check_eq("t4_start_ignored", {31'd0, bus.halted}, 32'd1);

    // 5: redirect to odd FF, wrap FE -> 00
    cycle(1'b0, 1'b1, 1'b1, 8'hFF);
    log_q.delete();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("t5_pc0", {24'd0, log_q[0].pc}, 32'hFE);
    check_eq("t5_pc1", {24'd0, log_q[1].pc}, 32'h00);
    check_eq("t5_ins1", {16'd0, log_q[1].ins}, 32'h21FE);

    // 6: reset with FIFO full, then idle until start
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00);
    do_reset();
    log_q.delete();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check_eq("t6_idle", log_q.size(), 32'd0);
    check_eq("t6_addr", {24'd0, bus.imem_addr}, 32'h00);

    // Random phase: sprinkle HALT words, random ready/redirect/start
    for (int i = 0; i < 6; i++) mem[$urandom_range(32, 127)] = 16'h0000;
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom % 8) == 0, ($urandom % 10) < 7, ($urandom % 20) == 0, 8'($urandom));
      if (i == 300) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
